sha3_absorb_packer: RTL

- Parametrised input packer in front of the Keccak-f[1600] permutation core.
- Collects NBEATS = 1600/DIN_W chunks into a 1600-bit state and presents it as a 5x5x64 lane array.
- Adds an internal beat counter, downstream backpressure, upstream stall, synchronous abort and optional index checking.

---
 rtl/sha3_pkg.sv | 23 ++
 rtl/sha3_state_map.sv | 12 +
 rtl/sha3_absorb_packer.sv | 114 +++++++++++
 3 files changed

// File: rtl/sha3_pkg.sv
// Shared types and helpers for the SHA-3 absorb datapath: lane geometry,
// packer FSM states and the flat-state to 5x5x64 lane array mapping.
package sha3_pkg;

  localparam int STATE_W = 1600;
  localparam int LANE_W  = 64;

  typedef logic [4:0][4:0][LANE_W-1:0] state_arr_t;

  typedef enum logic {FILL, FULL} pack_st_e;

  // Lane (x,y) occupies bits 64*(5y+x) .. 64*(5y+x)+63 of the flat state.
  function automatic state_arr_t to_state_arr(input logic [STATE_W-1:0] s);
    state_arr_t a;
    for (int x = 0; x < 5; x++) begin
      for (int y = 0; y < 5; y++) begin
        a[x][y] = s[LANE_W*(5*y+x) +: LANE_W];
      end
    end
    return a;
  endfunction

endpackage

// File: rtl/sha3_state_map.sv
// Combinational flat-state to lane-array view; also reused at the
// permutation output.
module sha3_state_map
  import sha3_pkg::*;
(
  input  logic [STATE_W-1:0] s_i,
  output state_arr_t         a_o
);

  assign a_o = to_state_arr(s_i);

endmodule

// File: rtl/sha3_absorb_packer.sv
// Packs DIN_W-bit beats into the 1600-bit Keccak state with backpressure,
// abort and zero-bubble hand-off. Optional index checking: SHA3_DIX_CHECK_EN.
module sha3_absorb_packer
  import sha3_pkg::*;
#(
  parameter int DIN_W = 200,
  parameter int IX_W  = 3
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 pushin,
  input  logic [DIN_W-1:0]                     din,
  input  logic [IX_W-1:0]                      dix,
  input  logic                                 clr,
  input  logic                                 stopin,
  output logic                                 stopout,
  output logic                                 pushout,
  output logic [4:0][4:0][63:0]                A,
  output logic [(STATE_W/DIN_W)*IX_W-1:0]      doutix,
  output logic                                 error
);

  localparam int NBEATS = STATE_W / DIN_W;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  if (STATE_W % DIN_W != 0) begin : g_bad_din_w
    $error("DIN_W must divide 1600 exactly");
  end
  if ((2 ** IX_W) < NBEATS) begin : g_bad_ix_w
    $error("IX_W too narrow to index every beat");
  end

  pack_st_e                 st_q, st_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [STATE_W-1:0]       s_q, s_d;
  logic [NBEATS*IX_W-1:0]   ix_q, ix_d;
  logic                     accept;
  logic                     bad_ix;
  logic                     wr_en;
  logic [CNT_W-1:0]         wr_idx;

  assign stopout = (st_q == FULL) && stopin;
  assign accept  = pushin && !stopout;
  // An abort in FILL makes the beat of the same cycle land in slot 0.
  assign wr_idx  = ((st_q == FILL) && clr) ? '0 : cnt_q;

`ifdef SHA3_DIX_CHECK_EN
  logic err_q;

  assign bad_ix = accept && (dix != IX_W'(wr_idx));
  assign error  = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_q | bad_ix;
  end
`else
  assign bad_ix = 1'b0;
  assign error  = 1'b0;
`endif

  assign wr_en = accept && !bad_ix;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    s_d   = s_q;
    ix_d  = ix_q;
    if ((st_q == FULL) && !stopin) st_d = FILL;
    if ((st_q == FILL) && clr)     cnt_d = '0;
    if (bad_ix) begin
      cnt_d = '0;
      st_d  = FILL;
    end else if (wr_en) begin
      for (int b = 0; b < NBEATS; b++) begin
        if (wr_idx == CNT_W'(b)) begin
          s_d[b*DIN_W +: DIN_W] = din;
          ix_d[b*IX_W +: IX_W]  = dix;
        end
      end
      // Wrap at NBEATS-1 explicitly; NBEATS need not be a power of two.
      if (wr_idx == LAST_BEAT) begin
        cnt_d = '0;
        st_d  = FULL;
      end else begin
        cnt_d = wr_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q  <= FILL;
      cnt_q <= '0;
      s_q   <= '0;
      ix_q  <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      s_q   <= s_d;
      ix_q  <= ix_d;
    end
  end

  assign pushout = (st_q == FULL);
  assign doutix  = ix_q;

  sha3_state_map u_map (
    .s_i (s_q),
    .a_o (A)
  );

endmodule
